// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the 8-bit ALU.
//   DATA_W    - operand/result width
//   alu_op_e  - 4-bit operation selector encoding
package alu_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_SHL  = 4'd4,
    OP_SHR  = 4'd5,
    OP_ROL  = 4'd6,
    OP_ROR  = 4'd7,
    OP_AND  = 4'd8,
    OP_OR   = 4'd9,
    OP_XOR  = 4'd10,
    OP_NOR  = 4'd11,
    OP_NAND = 4'd12,
    OP_XNOR = 4'd13,
    OP_GT   = 4'd14,
    OP_EQ   = 4'd15
  } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU datapath.
//   a_i, b_i  - unsigned operands
//   sel_i     - operation select (alu_op_e encoding)
//   result_o  - 8-bit result (truncated)
//   carry_o   - carry/borrow/status bit, meaning depends on the opcode
module alu_core
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [3:0]        sel_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o
);

  alu_op_e           op;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [2*DATA_W-1:0] prod;

  assign op   = alu_op_e'(sel_i);
  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  // Top bit of the widened difference is the borrow (set when a < b).
  assign diff = {1'b0, a_i} - {1'b0, b_i};
  assign prod = (2*DATA_W)'(a_i) * (2*DATA_W)'(b_i);

  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    unique case (op)
      OP_ADD: begin
        result_o = sum[DATA_W-1:0];
        carry_o  = sum[DATA_W];
      end
      OP_SUB: begin
        result_o = diff[DATA_W-1:0];
        carry_o  = diff[DATA_W];
      end
      OP_MUL: begin
        result_o = prod[DATA_W-1:0];
        carry_o  = |prod[2*DATA_W-1:DATA_W];
      end
      OP_DIV: begin
        // Divide by zero saturates and flags via the status bit.
        if (b_i == '0) begin
          result_o = '1;
          carry_o  = 1'b1;
        end else begin
          result_o = a_i / b_i;
        end
      end
      OP_SHL: begin
        result_o = {a_i[DATA_W-2:0], 1'b0};
        carry_o  = a_i[DATA_W-1];
      end
      OP_SHR: begin
        result_o = {1'b0, a_i[DATA_W-1:1]};
        carry_o  = a_i[0];
      end
      OP_ROL:  result_o = {a_i[DATA_W-2:0], a_i[DATA_W-1]};
      OP_ROR:  result_o = {a_i[0], a_i[DATA_W-1:1]};
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_NOR:  result_o = ~(a_i | b_i);
      OP_NAND: result_o = ~(a_i & b_i);
      OP_XNOR: result_o = ~(a_i ^ b_i);
      OP_GT:   result_o = (a_i > b_i)  ? DATA_W'(1) : '0;
      OP_EQ:   result_o = (a_i == b_i) ? DATA_W'(1) : '0;
      default: begin
        result_o = '0;
        carry_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_8bit.sv
// alu_8bit: registered 8-bit ALU, one-cycle latency, one operation per cycle.
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset (clears outputs immediately)
//   a, b    - unsigned operands
//   alu_sel - operation select
//   alu_out - registered result
//   cout    - registered carry/status bit
module alu_8bit
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        alu_sel,
  output logic [DATA_W-1:0] alu_out,
  output logic              cout
);

  logic [DATA_W-1:0] alu_out_d, alu_out_q;
  logic              cout_d, cout_q;

  alu_core u_core (
    .a_i      (a),
    .b_i      (b),
    .sel_i    (alu_sel),
    .result_o (alu_out_d),
    .carry_o  (cout_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_q <= '0;
      cout_q    <= 1'b0;
    end else begin
      alu_out_q <= alu_out_d;
      cout_q    <= cout_d;
    end
  end

  assign alu_out = alu_out_q;
  assign cout    = cout_q;

endmodule

// File: tb/tb_alu_8bit.sv
module tb_alu_8bit;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out;
  logic       cout;

  int checks   = 0;
  int failures = 0;

  alu_8bit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .alu_sel (alu_sel),
    .alu_out (alu_out),
    .cout    (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one operation, wait for the edge, check the registered result.
  task automatic op(input string tag, input logic [3:0] sel, input logic [7:0] av,
                    input logic [7:0] bv, input logic [7:0] eo, input logic ec);
    a = av; b = bv; alu_sel = sel;
    @(posedge clk); #1;
    chk({tag, "_out"}, alu_out, eo);
    chk({tag, "_cout"}, {7'd0, cout}, {7'd0, ec});
  endtask

  // Arithmetic reference built from integer math rather than bit slicing.
  task automatic ref_model(input logic [3:0] sel, input logic [7:0] x, input logic [7:0] y,
                           output logic [7:0] o, output logic c);
    int ia, ib, r;
    ia = int'(x); ib = int'(y); r = 0; c = 1'b0;
    case (sel)
      4'd0:  begin r = ia + ib; c = (r > 255); end
      4'd1:  begin r = (ia - ib + 256) % 256; c = (ia < ib); end
      4'd2:  begin r = ia * ib; c = ((r / 256) != 0); end
      4'd3:  begin if (ib == 0) begin r = 255; c = 1'b1; end else r = ia / ib; end
      4'd4:  begin r = ia * 2; c = (ia >= 128); end
      4'd5:  begin r = ia / 2; c = (ia % 2) == 1; end
      4'd6:  r = (ia * 2) % 256 + ia / 128;
      4'd7:  r = ia / 2 + (ia % 2) * 128;
      4'd8:  r = int'(x & y);
      4'd9:  r = int'(x | y);
      4'd10: r = int'(x ^ y);
      4'd11: r = 255 - int'(x | y);
      4'd12: r = 255 - int'(x & y);
      4'd13: r = 255 - int'(x ^ y);
      4'd14: r = (ia > ib) ? 1 : 0;
      default: r = (ia == ib) ? 1 : 0;
    endcase
    o = 8'(r % 256);
  endtask

  initial begin
    logic [7:0] eo;
    logic       ec;

    rst_n = 1'b0; a = 8'h00; b = 8'h00; alu_sel = 4'd0;
    #2;
    chk("reset_out", alu_out, 8'h00);
    chk("reset_cout", {7'd0, cout}, 8'h00);
    @(posedge clk); #1;
    chk("reset_hold_out", alu_out, 8'h00);
    rst_n = 1'b1;

    // Opcode sweep with a=200, b=60.
    op("ADD",  4'd0,  8'hC8, 8'h3C, 8'h04, 1'b1);
    op("SUB",  4'd1,  8'hC8, 8'h3C, 8'h8C, 1'b0);
    op("MUL",  4'd2,  8'hC8, 8'h3C, 8'hE0, 1'b1);
    op("DIV",  4'd3,  8'hC8, 8'h3C, 8'h03, 1'b0);
    op("SHL",  4'd4,  8'hC8, 8'h3C, 8'h90, 1'b1);
    op("SHR",  4'd5,  8'hC8, 8'h3C, 8'h64, 1'b0);
    op("ROL",  4'd6,  8'hC8, 8'h3C, 8'h91, 1'b0);
    op("ROR",  4'd7,  8'hC8, 8'h3C, 8'h64, 1'b0);
    op("AND",  4'd8,  8'hC8, 8'h3C, 8'h08, 1'b0);
    op("OR",   4'd9,  8'hC8, 8'h3C, 8'hFC, 1'b0);
    op("XOR",  4'd10, 8'hC8, 8'h3C, 8'hF4, 1'b0);
    op("NOR",  4'd11, 8'hC8, 8'h3C, 8'h03, 1'b0);
    op("NAND", 4'd12, 8'hC8, 8'h3C, 8'hF7, 1'b0);
    op("XNOR", 4'd13, 8'hC8, 8'h3C, 8'h0B, 1'b0);
    op("GT",   4'd14, 8'hC8, 8'h3C, 8'h01, 1'b0);
    op("EQ",   4'd15, 8'hC8, 8'h3C, 8'h00, 1'b0);

    // Boundary cases.
    op("DIV0",    4'd3,  8'h10, 8'h00, 8'hFF, 1'b1);
    op("SUB_eq",  4'd1,  8'h55, 8'h55, 8'h00, 1'b0);
    op("EQ_eq",   4'd15, 8'h55, 8'h55, 8'h01, 1'b0);
    op("GT_eq",   4'd14, 8'h55, 8'h55, 8'h00, 1'b0);
    op("SUB_brw", 4'd1,  8'h01, 8'h02, 8'hFF, 1'b1);
    op("ROR_lsb", 4'd7,  8'h01, 8'hAA, 8'h80, 1'b0);
    op("SHR_lsb", 4'd5,  8'h81, 8'h00, 8'h40, 1'b1);
    op("GT_lt",   4'd14, 8'h01, 8'h02, 8'h00, 1'b0);

    // Mid-stream asynchronous reset: output clears without a clock edge.
    op("pre_rst", 4'd0, 8'hFF, 8'h01, 8'h00, 1'b1);
    op("pre_rst2", 4'd9, 8'hA5, 8'h5A, 8'hFF, 1'b0);
    a = 8'h12; b = 8'h34; alu_sel = 4'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", alu_out, 8'h00);
    chk("async_rst_cout", {7'd0, cout}, 8'h00);
    @(posedge clk); #1;
    chk("rst_held_out", alu_out, 8'h00);
    rst_n = 1'b1;
    op("post_rst", 4'd2, 8'h10, 8'h10, 8'h00, 1'b1);

    // Random back-to-back operations with a stability check between edges.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      logic [3:0] rs;
      ra = 8'($urandom); rb = 8'($urandom); rs = 4'($urandom_range(0, 15));
      if (i > 0) begin
        a = ra; b = rb; alu_sel = rs;
        #3;
        chk("hold_out", alu_out, eo);
        chk("hold_cout", {7'd0, cout}, {7'd0, ec});
      end else begin
        a = ra; b = rb; alu_sel = rs;
      end
      ref_model(rs, ra, rb, eo, ec);
      @(posedge clk); #1;
      chk("rand_out", alu_out, eo);
      chk("rand_cout", {7'd0, cout}, {7'd0, ec});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
